instr_fetch_queue: RTL and testbench

Instruction fetch front end that owns the program counter, requests instruction words from instruction memory over a req/ack handshake, and buffers returned words in a small prefetch queue. It presents one instruction per cycle to the IF/ID pipeline register. It honours the hazard unit's advance/stall signal and the decode stage's branch/jump redirect. It sits directly upstream of the IF/ID register and replaces the free-running PC path of the fetch stage.

---
 rtl/instr_fetch_queue.sv | 101 ++++++++++
 tb/tb_instr_fetch_queue.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: fetch front end owning the PC, issuing imem requests
// and buffering returned words in a small prefetch queue for IF/ID.
module instr_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        Clk,
    input  logic        Rst_n,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemRdata,
    input  logic        Advance,
    input  logic        Redirect,
    input  logic [31:0] TargetAddr,
    output logic        IfValid,
    output logic [31:0] IfInstr,
    output logic [31:0] IfPC,
    output logic [31:0] IfNextPC
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [31:0] ALIGN = 32'hFFFF_FFFC;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   pc_mem_d    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   instr_mem_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push;
    logic          pop;

    // Request and head outputs depend on registered state only (plus reset).
    assign ImemReq  = Rst_n && (cnt_q < FULL);
    assign ImemAddr = fetch_pc_q;
    assign IfValid  = (cnt_q != '0);
    assign IfInstr  = IfValid ? instr_mem_q[rd_ptr_q] : '0;
    assign IfPC     = IfValid ? pc_mem_q[rd_ptr_q] : '0;
    assign IfNextPC = IfValid ? (pc_mem_q[rd_ptr_q] + 32'd4) : '0;

    assign push = ImemReq && ImemAck && !Redirect;
    assign pop  = Advance && IfValid && !Redirect;

    // Next-state: redirect flushes the queue and retargets the fetch PC.
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        cnt_d       = cnt_q;
        if (Redirect) begin
            fetch_pc_d = TargetAddr & ALIGN;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            cnt_d      = '0;
        end else begin
            if (push) begin
                pc_mem_d[wr_ptr_q]    = fetch_pc_q;
                instr_mem_d[wr_ptr_q] = ImemRdata;
                wr_ptr_d              = wr_ptr_q + PW'(1);
                fetch_pc_d            = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                cnt_d = cnt_q + CW'(1);
            end else if (pop && !push) begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    // State registers with asynchronous clear to the reset PC.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            fetch_pc_q <= RESET_PC & ALIGN;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            pc_mem_q    <= pc_mem_d;
            instr_mem_q <= instr_mem_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed checks of fetch, stall, redirect,
// ack bubbles, PC wrap and asynchronous reset.
module tb_instr_fetch_queue;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemAck;
    logic [31:0] ImemRdata;
    logic        Advance;
    logic        Redirect;
    logic [31:0] TargetAddr;
    logic        IfValid;
    logic [31:0] IfInstr;
    logic [31:0] IfPC;
    logic [31:0] IfNextPC;

    logic        w_rst_n;
    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_rdata;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic [31:0] w_npc;

    int n_chk = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    assign ImemRdata = 32'h1000_0000 + ImemAddr;
    assign w_rdata   = 32'h1000_0000 + w_addr;

    instr_fetch_queue #(.RESET_PC(32'h0), .DEPTH(2)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr),
        .ImemAck(ImemAck), .ImemRdata(ImemRdata),
        .Advance(Advance), .Redirect(Redirect),
        .TargetAddr(TargetAddr),
        .IfValid(IfValid), .IfInstr(IfInstr),
        .IfPC(IfPC), .IfNextPC(IfNextPC)
    );

    instr_fetch_queue #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_w (
        .Clk(Clk), .Rst_n(w_rst_n),
        .ImemReq(w_req), .ImemAddr(w_addr),
        .ImemAck(1'b1), .ImemRdata(w_rdata),
        .Advance(1'b1), .Redirect(1'b0),
        .TargetAddr(32'h0),
        .IfValid(w_valid), .IfInstr(w_instr),
        .IfPC(w_pc), .IfNextPC(w_npc)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Rst_n      = 1'b0;
        w_rst_n    = 1'b0;
        ImemAck    = 1'b1;
        Advance    = 1'b1;
        Redirect   = 1'b0;
        TargetAddr = 32'h0;
        step();
        step();
        check("rst_req", {31'h0, ImemReq}, 32'h0);
        check("rst_addr", ImemAddr, 32'h0);
        check("rst_valid", {31'h0, IfValid}, 32'h0);
        check("rst_instr", IfInstr, 32'h0);
        check("rst_pc", IfPC, 32'h0);
        check("rst_npc", IfNextPC, 32'h0);

        Rst_n = 1'b1;
        #1;
        check("first_req", {31'h0, ImemReq}, 32'h1);
        check("first_addr", ImemAddr, 32'h0);

        for (int m = 0; m < 3; m++) begin
            step();
            check("seq_valid", {31'h0, IfValid}, 32'h1);
            check("seq_pc", IfPC, 32'(4 * m));
            check("seq_instr", IfInstr, 32'h1000_0000 + 32'(4 * m));
            check("seq_npc", IfNextPC, 32'(4 * m + 4));
        end

        Advance = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("stall_pc", IfPC, 32'h8);
            check("stall_req", {31'h0, ImemReq}, 32'h0);
            check("stall_addr", ImemAddr, 32'h10);
        end
        Advance = 1'b1;
        step();
        check("resume_pc12", IfPC, 32'hC);
        check("resume_req", {31'h0, ImemReq}, 32'h1);
        step();
        check("resume_pc16", IfPC, 32'h10);
        check("resume_valid", {31'h0, IfValid}, 32'h1);

        Advance = 1'b0;
        step();
        check("pre_rst_req", {31'h0, ImemReq}, 32'h0);
        #2;
        Rst_n = 1'b0;
        #1;
        check("arst_valid", {31'h0, IfValid}, 32'h0);
        check("arst_req", {31'h0, ImemReq}, 32'h0);
        check("arst_addr", ImemAddr, 32'h0);
        #1;
        Rst_n   = 1'b1;
        Advance = 1'b1;
        for (int m = 0; m < 3; m++) begin
            step();
            check("restart_pc", IfPC, 32'(4 * m));
        end

        Redirect   = 1'b1;
        TargetAddr = 32'h0000_0043;
        step();
        Redirect = 1'b0;
        check("redir_valid", {31'h0, IfValid}, 32'h0);
        check("redir_addr", ImemAddr, 32'h40);
        check("redir_instr", IfInstr, 32'h0);
        step();
        check("redir_pc", IfPC, 32'h40);
        check("redir_tinstr", IfInstr, 32'h1000_0040);

        ImemAck = 1'b0;
        step();
        check("bub1_valid", {31'h0, IfValid}, 32'h0);
        check("bub1_instr", IfInstr, 32'h0);
        step();
        check("bub2_valid", {31'h0, IfValid}, 32'h0);
        check("bub2_pc", IfPC, 32'h0);
        ImemAck = 1'b1;
        step();
        check("bub_end_pc", IfPC, 32'h44);
        check("bub_end_valid", {31'h0, IfValid}, 32'h1);

        w_rst_n = 1'b1;
        #1;
        check("wrap_addr0", w_addr, 32'hFFFF_FFF8);
        step();
        check("wrap_pc0", w_pc, 32'hFFFF_FFF8);
        step();
        check("wrap_pc1", w_pc, 32'hFFFF_FFFC);
        check("wrap_npc1", w_npc, 32'h0);
        step();
        check("wrap_pc2", w_pc, 32'h0);
        check("wrap_instr2", w_instr, 32'h1000_0000);
        check("wrap_valid2", {31'h0, w_valid}, 32'h1);
        check("wrap_req2", {31'h0, w_req}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
